// File: rtl/axi_read_arbiter.sv
// Two-master read arbiter: icache and dcache share one AXI AR/R channel, one burst at a time.
// Optional AXI_ARB_ROUND_ROBIN_EN: tie-break alternates instead of fixed dcache priority.
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ic_arvalid,
  input  logic [ADDR_WIDTH-1:0] ic_araddr,
  input  logic [7:0]            ic_arlen,
  input  logic [2:0]            ic_arsize,
  input  logic [1:0]            ic_arburst,
  output logic                  ic_arready,
  output logic                  ic_rvalid,
  output logic [DATA_WIDTH-1:0] ic_rdata,
  output logic                  ic_rlast,
  input  logic                  ic_rready,
  input  logic                  dc_arvalid,
  input  logic [ADDR_WIDTH-1:0] dc_araddr,
  input  logic [7:0]            dc_arlen,
  input  logic [2:0]            dc_arsize,
  input  logic [1:0]            dc_arburst,
  output logic                  dc_arready,
  output logic                  dc_rvalid,
  output logic [DATA_WIDTH-1:0] dc_rdata,
  output logic                  dc_rlast,
  input  logic                  dc_rready,
  output logic                  m_axi_arvalid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rvalid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rlast,
  output logic                  m_axi_rready,
  output logic                  instruction_cache_reading,
  output logic                  data_cache_reading,
  output logic                  len_error
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_req_t;

  state_t     state;
  ar_req_t    req;
  logic       gnt_ic, gnt_dc;
  logic [7:0] beat_cnt;
  logic       dc_wins, in_data, route_ic, route_dc, beat_ok;

`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic last_dc;  // 1 when the dcache held the most recent grant
  assign dc_wins = dc_arvalid & (~ic_arvalid | ~last_dc);
`else
  assign dc_wins = dc_arvalid;
`endif

  // Request acceptance is combinational so the winner sees arready in its request cycle.
  assign ic_arready = (state == IDLE) & ic_arvalid & ~dc_wins;
  assign dc_arready = (state == IDLE) & dc_wins;

  assign in_data  = (state == DATA);
  assign route_ic = in_data & gnt_ic;
  assign route_dc = in_data & gnt_dc;

  assign m_axi_rready = (route_ic & ic_rready) | (route_dc & dc_rready);
  assign beat_ok      = m_axi_rvalid & m_axi_rready;

  assign ic_rvalid = route_ic & m_axi_rvalid;
  assign ic_rlast  = route_ic & m_axi_rlast;
  assign ic_rdata  = route_ic ? m_axi_rdata : '0;
  assign dc_rvalid = route_dc & m_axi_rvalid;
  assign dc_rlast  = route_dc & m_axi_rlast;
  assign dc_rdata  = route_dc ? m_axi_rdata : '0;

  assign m_axi_arvalid = (state == ADDR);
  assign m_axi_araddr  = req.addr;
  assign m_axi_arlen   = req.len;
  assign m_axi_arsize  = req.size;
  assign m_axi_arburst = req.burst;

  assign instruction_cache_reading = (state != IDLE) & gnt_ic;
  assign data_cache_reading        = (state != IDLE) & gnt_dc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req       <= '0;
      gnt_ic    <= 1'b0;
      gnt_dc    <= 1'b0;
      beat_cnt  <= '0;
      len_error <= 1'b0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
      last_dc   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ic_arvalid | dc_arvalid) begin
            req    <= dc_wins ? '{dc_araddr, dc_arlen, dc_arsize, dc_arburst}
                              : '{ic_araddr, ic_arlen, ic_arsize, ic_arburst};
            gnt_dc <= dc_wins;
            gnt_ic <= ~dc_wins;
`ifdef AXI_ARB_ROUND_ROBIN_EN
            last_dc <= dc_wins;
`endif
            state  <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (beat_ok) begin
            beat_cnt <= beat_cnt + 8'd1;
            // rlast must coincide exactly with the beat whose count equals arlen
            if (m_axi_rlast != (beat_cnt == req.len)) len_error <= 1'b1;
            if (m_axi_rlast) begin
              gnt_ic <= 1'b0;
              gnt_dc <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized bench for axi_read_arbiter with a transaction-level reference model.
module tb_axi_read_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        ic_arvalid, dc_arvalid, ic_arready, dc_arready;
  logic [63:0] ic_araddr, dc_araddr;
  logic [7:0]  ic_arlen, dc_arlen;
  logic [2:0]  ic_arsize, dc_arsize;
  logic [1:0]  ic_arburst, dc_arburst;
  logic        ic_rvalid, dc_rvalid, ic_rlast, dc_rlast, ic_rready, dc_rready;
  logic [63:0] ic_rdata, dc_rdata;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast, m_axi_rready;
  logic [63:0] m_axi_araddr, m_axi_rdata;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        instruction_cache_reading, data_cache_reading, len_error;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  bit icp, dcp;
  bit exp_len_err;
  bit last_dc_m;

  always #5 clk = ~clk;

  axi_read_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_arvalid(ic_arvalid), .ic_araddr(ic_araddr), .ic_arlen(ic_arlen), .ic_arsize(ic_arsize),
    .ic_arburst(ic_arburst), .ic_arready(ic_arready), .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata),
    .ic_rlast(ic_rlast), .ic_rready(ic_rready),
    .dc_arvalid(dc_arvalid), .dc_araddr(dc_araddr), .dc_arlen(dc_arlen), .dc_arsize(dc_arsize),
    .dc_arburst(dc_arburst), .dc_arready(dc_arready), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .dc_rlast(dc_rlast), .dc_rready(dc_rready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
    .m_axi_rready(m_axi_rready),
    .instruction_cache_reading(instruction_cache_reading), .data_cache_reading(data_cache_reading),
    .len_error(len_error)
  );

  // Arbitration rule: lone requester wins; ties go to dcache, or alternate in round-robin builds.
  function automatic bit pick_dc();
    if (icp && dcp) begin
`ifdef AXI_ARB_ROUND_ROBIN_EN
      return !last_dc_m;
`else
      return 1'b1;
`endif
    end
    return dcp;
  endfunction

  task automatic set_ic(input logic [63:0] a, input logic [7:0] l);
    icp = 1; ic_arvalid = 1; ic_araddr = a; ic_arlen = l;
    ic_arsize = 3'($urandom_range(0, 7)); ic_arburst = 2'($urandom_range(0, 3));
  endtask

  task automatic set_dc(input logic [63:0] a, input logic [7:0] l);
    dcp = 1; dc_arvalid = 1; dc_araddr = a; dc_arlen = l;
    dc_arsize = 3'($urandom_range(0, 7)); dc_arburst = 2'($urandom_range(0, 3));
  endtask

  // Serve one burst from the IDLE cycle in which requests are already presented.
  // lidx: beat index carrying rlast (-1 = correct, -2 = random wrong). rmode: 0 rready=1, 1 random, 2 low on data cycles 2,3.
  task automatic serve_one(input int ar_dly, input int lidx, input int rmode, output int nbeats);
    bit wdc, v, rdy, done, lb;
    logic [63:0] a, d;
    logic [7:0] l;
    logic [2:0] sz;
    logic [1:0] bu;
    int last_idx, beat, cyc;
    #1;
    wdc = pick_dc();
    a = wdc ? dc_araddr : ic_araddr; l = wdc ? dc_arlen : ic_arlen;
    sz = wdc ? dc_arsize : ic_arsize; bu = wdc ? dc_arburst : ic_arburst;
    n_chk++;
    if ({ic_arready, dc_arready} !== {!wdc, wdc}) begin
      n_fail++; $display("FAIL arready: got ic=%b dc=%b exp ic=%b dc=%b", ic_arready, dc_arready, !wdc, wdc);
    end
    n_chk++;
    if ({instruction_cache_reading, data_cache_reading, m_axi_arvalid, m_axi_rready} !== 4'b0) begin
      n_fail++; $display("FAIL idle_outputs: got %b exp 0000",
        {instruction_cache_reading, data_cache_reading, m_axi_arvalid, m_axi_rready});
    end
    last_dc_m = wdc;
    @(posedge clk); #1;
    if (wdc) begin dcp = 0; dc_arvalid = 0; end else begin icp = 0; ic_arvalid = 0; end
    // stray slave beat while in ADDR must be ignored
    m_axi_rvalid = 1; m_axi_rlast = 1; m_axi_rdata = {$urandom, $urandom};
    ic_rready = 1; dc_rready = 1;
    #1;
    n_chk++;
    if ({m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst} !== {1'b1, a, l, sz, bu}) begin
      n_fail++; $display("FAIL ar_fwd: got v=%b a=%h l=%0d exp v=1 a=%h l=%0d", m_axi_arvalid, m_axi_araddr, m_axi_arlen, a, l);
    end
    n_chk++;
    if ({instruction_cache_reading, data_cache_reading, m_axi_rready, ic_rvalid, dc_rvalid, ic_rlast, dc_rlast}
        !== {!wdc, wdc, 5'b0}) begin
      n_fail++; $display("FAIL addr_phase: got flags=%b%b rready=%b rv=%b%b exp flags=%b%b rest 0",
        instruction_cache_reading, data_cache_reading, m_axi_rready, ic_rvalid, dc_rvalid, !wdc, wdc);
    end
    m_axi_rvalid = 0; m_axi_rlast = 0; ic_rready = 0; dc_rready = 0;
    repeat (ar_dly) begin
      @(posedge clk); #1;
      n_chk++;
      if ({m_axi_arvalid, m_axi_araddr, m_axi_arlen} !== {1'b1, a, l}) begin
        n_fail++; $display("FAIL ar_hold: got v=%b a=%h exp v=1 a=%h", m_axi_arvalid, m_axi_araddr, a);
      end
    end
    m_axi_arready = 1;
    @(posedge clk); #1;
    m_axi_arready = 0;
    if (lidx == -1) last_idx = l;
    else if (lidx == -2) last_idx = (l > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, l - 1) : l + $urandom_range(1, 2);
    else last_idx = lidx;
    beat = 0; cyc = 0; done = 0;
    while (!done && cyc < 2000) begin
      v   = (rmode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      rdy = (rmode == 1) ? ($urandom_range(0, 2) != 0) : (rmode == 2) ? !(cyc == 2 || cyc == 3) : 1'b1;
      d   = {$urandom, $urandom};
      lb  = v && (beat == last_idx);
      m_axi_rvalid = v; m_axi_rdata = d; m_axi_rlast = lb;
      if (wdc) begin dc_rready = rdy; ic_rready = 1'($urandom); end
      else begin ic_rready = rdy; dc_rready = 1'($urandom); end
      #1;
      n_chk++;
      if (m_axi_rready !== rdy) begin
        n_fail++; $display("FAIL m_rready: got %b exp %b (cyc %0d)", m_axi_rready, rdy, cyc);
      end
      n_chk++;
      if (wdc ? ({dc_rvalid, dc_rlast, ic_rvalid, ic_rlast, ic_rdata} !== {v, lb, 2'b0, 64'd0})
              : ({ic_rvalid, ic_rlast, dc_rvalid, dc_rlast, dc_rdata} !== {v, lb, 2'b0, 64'd0})) begin
        n_fail++; $display("FAIL r_route: got ic v/l=%b%b dc v/l=%b%b exp winner(dc=%b) v/l=%b%b loser 00",
          ic_rvalid, ic_rlast, dc_rvalid, dc_rlast, wdc, v, lb);
      end
      if (v) begin
        n_chk++;
        if ((wdc ? dc_rdata : ic_rdata) !== d) begin
          n_fail++; $display("FAIL r_data: got %h exp %h", wdc ? dc_rdata : ic_rdata, d);
        end
      end
      n_chk++;
      if ({instruction_cache_reading, data_cache_reading} !== {!wdc, wdc}) begin
        n_fail++; $display("FAIL data_flags: got %b%b exp %b%b", instruction_cache_reading, data_cache_reading, !wdc, wdc);
      end
      if (v && rdy) begin
        if (beat == last_idx) done = 1;
        beat++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_axi_rvalid = 0; m_axi_rlast = 0; ic_rready = 0; dc_rready = 0;
    if (!done) begin
      n_fail++; $display("FAIL burst_timeout: beats=%0d exp %0d", beat, last_idx + 1);
    end
    exp_len_err = exp_len_err | (last_idx != int'(l));
    nbeats = beat;
    #1;
    n_chk++;
    if ({len_error, instruction_cache_reading, data_cache_reading, m_axi_rready} !== {exp_len_err, 3'b0}) begin
      n_fail++; $display("FAIL post_burst: got len_err=%b flags=%b%b exp len_err=%b flags=00",
        len_error, instruction_cache_reading, data_cache_reading, exp_len_err);
    end
  endtask

  task automatic test_reset;
    reset = 1; m_axi_rvalid = 1; m_axi_rlast = 1; m_axi_rdata = '1; ic_rready = 1; dc_rready = 1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({ic_arready, dc_arready, ic_rvalid, dc_rvalid, ic_rlast, dc_rlast, m_axi_arvalid, m_axi_rready,
         instruction_cache_reading, data_cache_reading, len_error, ic_rdata, dc_rdata, m_axi_araddr} !== '0) begin
      n_fail++; $display("FAIL reset_state: some output nonzero (rv=%b%b flags=%b%b len_err=%b)",
        ic_rvalid, dc_rvalid, instruction_cache_reading, data_cache_reading, len_error);
    end
    m_axi_rvalid = 0; m_axi_rlast = 0; ic_rready = 0; dc_rready = 0;
    reset = 0; exp_len_err = 0; last_dc_m = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_ic;
    int nb;
    set_ic(64'h1000, 8'd7);
    serve_one(2, -1, 0, nb);
    n_chk++;
    if (nb !== 8) begin n_fail++; $display("FAIL single_ic_beats: got %0d exp 8", nb); end
  endtask

  task automatic test_tie;
    int nb;
    set_ic(64'h3000, 8'd7); set_dc(64'h2000, 8'd0);
    serve_one(0, -1, 0, nb);
    serve_one(1, -1, 0, nb);
    set_dc(64'h2400, 8'd1);
    serve_one(0, -1, 0, nb);
    set_ic(64'h3000, 8'd7); set_dc(64'h2000, 8'd0);
    serve_one(0, -1, 0, nb);
    serve_one(0, -1, 1, nb);
  endtask

  task automatic test_backpressure;
    int nb;
    set_dc(64'h4000, 8'd3);
    serve_one(1, -1, 2, nb);
    n_chk++;
    if (nb !== 4) begin n_fail++; $display("FAIL backpressure_beats: got %0d exp 4", nb); end
  endtask

  task automatic test_len_error;
    int nb;
    set_dc(64'h5000, 8'd3);
    serve_one(0, 2, 0, nb);
    set_ic(64'h5100, 8'd2);
    serve_one(0, -1, 0, nb);
  endtask

  task automatic test_len255;
    int nb;
    reset = 1; @(posedge clk); #1; reset = 0; exp_len_err = 0; last_dc_m = 0;
    set_ic(64'h6000, 8'd255);
    serve_one(0, -1, 0, nb);
    n_chk++;
    if (nb !== 256) begin n_fail++; $display("FAIL len255_beats: got %0d exp 256", nb); end
  endtask

  task automatic test_reset_mid_burst;
    int nb;
    set_ic(64'h7000, 8'd7);
    @(posedge clk); #1;
    ic_arvalid = 0; icp = 0; m_axi_arready = 1;
    @(posedge clk); #1;
    m_axi_arready = 0; ic_rready = 1; m_axi_rvalid = 1; m_axi_rdata = 64'h1234;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_chk++;
    if (ic_rvalid !== 1'b1) begin n_fail++; $display("FAIL mid_burst_rvalid: got %b exp 1", ic_rvalid); end
    reset = 1;
    @(posedge clk); #1;
    n_chk++;
    if ({ic_rvalid, dc_rvalid, m_axi_arvalid, m_axi_rready, instruction_cache_reading, data_cache_reading,
         len_error, ic_rdata} !== '0) begin
      n_fail++; $display("FAIL mid_burst_reset: got rv=%b rready=%b flag=%b exp all 0", ic_rvalid, m_axi_rready,
        instruction_cache_reading);
    end
    reset = 0; m_axi_rvalid = 0; ic_rready = 0; exp_len_err = 0; last_dc_m = 0;
    set_ic(64'h7100, 8'd3);
    serve_one(1, -1, 0, nb);
    n_chk++;
    if (nb !== 4) begin n_fail++; $display("FAIL post_reset_beats: got %0d exp 4", nb); end
  endtask

  task automatic test_random;
    int nb;
    for (int i = 0; i < 30; i++) begin
      if (!icp && $urandom_range(0, 1) == 1) set_ic({32'd0, $urandom}, 8'($urandom_range(0, 7)));
      if (!dcp && $urandom_range(0, 1) == 1) set_dc({32'd0, $urandom}, 8'($urandom_range(0, 7)));
      if (!icp && !dcp) set_ic({32'd0, $urandom}, 8'($urandom_range(0, 7)));
      serve_one($urandom_range(0, 3), ($urandom_range(0, 5) == 0) ? -2 : -1, $urandom_range(0, 1), nb);
    end
    while (icp || dcp) serve_one(0, -1, 0, nb);
  endtask

  initial begin
    reset = 1; icp = 0; dcp = 0;
    ic_arvalid = 0; ic_araddr = 0; ic_arlen = 0; ic_arsize = 0; ic_arburst = 0; ic_rready = 0;
    dc_arvalid = 0; dc_araddr = 0; dc_arlen = 0; dc_arsize = 0; dc_arburst = 0; dc_rready = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rlast = 0;
    test_reset;
    test_single_ic;
    test_tie;
    test_backpressure;
    test_len_error;
    test_len255;
    test_reset_mid_burst;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the single AXI read channel (AR/R) between the instruction cache and the data cache.
- Grants one requester at a time and holds the grant for its whole burst. Routes R beats only to the granted requester.
- Drives the instruction_cache_reading / data_cache_reading ownership flags consumed by both caches.
- Sits between the fetch/memory-stage caches and the top-level m_axi read ports.

Parameters:
- ADDR_WIDTH, 64, AR address width
- DATA_WIDTH, 64, R data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ic_arvalid  in  1  icache read-address request
- ic_araddr  in  ADDR_WIDTH  icache burst address
- ic_arlen  in  8  icache burst length (beats-1)
- ic_arsize  in  3  icache beat size
- ic_arburst  in  2  icache burst type
- ic_arready  out  1  icache request accepted
- ic_rvalid  out  1  beat valid to icache
- ic_rdata  out  DATA_WIDTH  beat data to icache
- ic_rlast  out  1  last beat to icache
- ic_rready  in  1  icache beat accept
- dc_arvalid, dc_araddr, dc_arlen, dc_arsize, dc_arburst, dc_arready, dc_rvalid, dc_rdata, dc_rlast, dc_rready: same widths/meanings for the dcache
- m_axi_arvalid  out  1; m_axi_araddr  out  ADDR_WIDTH; m_axi_arlen  out  8; m_axi_arsize  out  3; m_axi_arburst  out  2
- m_axi_arready  in  1
- m_axi_rvalid  in  1; m_axi_rdata  in  DATA_WIDTH; m_axi_rlast  in  1
- m_axi_rready  out  1
- instruction_cache_reading  out  1  icache owns the channel
- data_cache_reading  out  1  dcache owns the channel
- len_error  out  1  sticky: burst length mismatch seen

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, grant none, all *_arready/*_rvalid/*_rlast = 0, *_rdata = 0, m_axi_arvalid = 0, m_axi_rready = 0, ownership flags 0, len_error 0, beat counter 0.
- States: IDLE, ADDR, DATA.
- IDLE:
  - If any *_arvalid, pick a winner (dc over ic by default).
  - Assert the winner's *_arready combinationally in the same cycle.
  - Latch the winner's addr/len/size/burst and grant. Next state ADDR.
  - The loser's arready stays 0; it must hold its request.
- ADDR:
  - m_axi_arvalid = 1 with the latched fields, held stable until m_axi_arready.
  - On handshake: clear beat counter, go to DATA.
- DATA:
  - m_axi_rready = granted requester's rready.
  - Granted requester's rvalid/rdata/rlast mirror m_axi_r*. The non-granted requester sees rvalid = 0, rlast = 0, rdata = 0.
  - Beat counter increments on each rvalid&rready.
  - On an accepted beat with m_axi_rlast = 1: go to IDLE.
- Ownership flags: the granted requester's flag = 1 while in ADDR or DATA; otherwise 0. The two flags are never high together.
- Latency:
  - Request in IDLE at cycle N → arready at N → m_axi_arvalid at N+1.
  - Minimum one IDLE cycle between bursts.
- len_error (sticky until reset) is set when either:
  - rlast is accepted with beat count ≠ latched arlen, or
  - the beat with count == arlen is accepted without rlast. In this case, keep routing beats until rlast.
- Simultaneous ic/dc requests in IDLE: priority rule applies. A new request arriving during ADDR/DATA waits.
- Beats with m_axi_rvalid outside DATA: ignored. m_axi_rready = 0 there.
- Reset mid-burst: immediate return to IDLE with reset values. Outstanding slave beats are not drained; they are the system reset's responsibility.
- Beat counter is 8 bits; arlen = 255 is handled without wrap error.

Optional Feature:
- Macro: AXI_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, the requester not granted last wins. The last-grant register resets to icache, so dcache wins the first tie.
- Undefined: fixed priority, dcache always wins ties. The icache may starve under continuous dcache traffic.

Test Plan:
- Single ic request, addr 0x1000, arlen 7, slave arready after 2 cycles, 8 beats → ic_arready at request cycle; m_axi_araddr 0x1000 held until handshake; ic receives 8 beats with rlast on the 8th; instruction_cache_reading 1 throughout; len_error 0.
- ic and dc request in the same cycle (dc addr 0x2000 arlen 0, ic addr 0x3000 arlen 7), macro off → dc served first with 1 beat; dc_rvalid never seen by ic; ic granted after one IDLE cycle.
- Same simultaneous stimulus repeated twice with AXI_ARB_ROUND_ROBIN_EN → first tie dc, second tie ic.
- dc burst arlen 3, dc_rready deasserted for 2 cycles mid-burst → m_axi_rready 0 for those cycles; no beats lost; 4 beats delivered.
- Slave asserts rlast on beat 3 of an arlen 3 burst (early) → len_error 1, state IDLE. Then a mismatch-free burst → len_error stays 1.
- reset asserted in DATA after 2 beats → next cycle all outputs at reset values; a new ic request is then served normally.
